// File: rtl/micro_sequencer_pkg.sv
// Shared encodings for the microprogram sequencer: next-address control codes,
// controller states and the two reserved micro-addresses.
package micro_seq_pkg;

    typedef enum logic [2:0] {
        SEQ_INC   = 3'b000,
        SEQ_MAP   = 3'b001,
        SEQ_JMP   = 3'b010,
        SEQ_JZ    = 3'b011,
        SEQ_JNZ   = 3'b100,
        SEQ_FETCH = 3'b101,
        SEQ_WAIT  = 3'b110,
        SEQ_HALT  = 3'b111
    } seq_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_WAITM,
        ST_HALT,
        ST_ERR
    } state_t;

    localparam int UADDR_FETCH    = 0;
    localparam int UADDR_UNMAPPED = 31;

endpackage

// File: rtl/micro_sequencer_if.sv
// Control-unit side of the sequencer: MAP ROM / control-store fields in,
// control-store address and status out.
interface micro_sequencer_if #(
    parameter int UADDR_W = 5,
    parameter int CNT_W   = 16
);
    logic               start;
    logic [UADDR_W-1:0] map_addr;
    logic [2:0]         mi_seq;
    logic [UADDR_W-1:0] mi_next;
    logic               z_flag;
    logic               mem_ready;

    logic [UADDR_W-1:0] upc;
    logic               busy;
    logic               stall;
    logic               done;
    logic               illegal;
    logic [CNT_W-1:0]   instr_cnt;

    modport master (
        output start, map_addr, mi_seq, mi_next, z_flag, mem_ready,
        input  upc, busy, stall, done, illegal, instr_cnt
    );

    modport slave (
        input  start, map_addr, mi_seq, mi_next, z_flag, mem_ready,
        output upc, busy, stall, done, illegal, instr_cnt
    );

endinterface

// File: rtl/micro_next_addr.sv
// Candidate next micro-address for a RUN cycle, chosen by the current
// microinstruction's next-address control field.
module micro_next_addr
    import micro_seq_pkg::*;
#(
    parameter int UADDR_W = 5
) (
    input  logic [2:0]         mi_seq,
    input  logic [UADDR_W-1:0] upc,
    input  logic [UADDR_W-1:0] map_addr,
    input  logic [UADDR_W-1:0] mi_next,
    input  logic               z_flag,
    input  logic               mem_ready,
    output logic [UADDR_W-1:0] next_upc
);

    logic [UADDR_W-1:0] upc_inc;

    // Natural width truncation gives the 31 -> 0 wrap.
    assign upc_inc = upc + UADDR_W'(1);

    always_comb begin
        // NOTE: default assigned first so no path leaves next_upc unassigned (no latch).
        next_upc = upc_inc;
        case (seq_t'(mi_seq))
            SEQ_INC:   next_upc = upc_inc;
            SEQ_MAP:   next_upc = map_addr;
            SEQ_JMP:   next_upc = mi_next;
            SEQ_JZ:    next_upc = z_flag ? mi_next : upc_inc;
            SEQ_JNZ:   next_upc = z_flag ? upc_inc : mi_next;
            SEQ_FETCH: next_upc = UADDR_W'(UADDR_FETCH);
            SEQ_WAIT:  next_upc = mem_ready ? upc_inc : upc;
            SEQ_HALT:  next_upc = upc;
            default:   next_upc = upc_inc;
        endcase
    end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: owns the uPC, the run/wait/halt/error controller,
// the illegal-opcode flag and the saturating dispatch counter.
module micro_sequencer
    import micro_seq_pkg::*;
#(
    parameter int UADDR_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    micro_sequencer_if.slave  bus
);

    localparam logic [UADDR_W-1:0] UPC_FETCH    = UADDR_W'(UADDR_FETCH);
    localparam logic [UADDR_W-1:0] UPC_UNMAPPED = UADDR_W'(UADDR_UNMAPPED);

    state_t             state, state_nx;
    logic [UADDR_W-1:0] upc_q, upc_nx, cand_upc;
    logic [CNT_W-1:0]   cnt_q, cnt_nx;
    logic               done_q, done_nx;
    logic               unmapped;

    micro_next_addr #(.UADDR_W(UADDR_W)) u_next_addr (
        .mi_seq    (bus.mi_seq),
        .upc       (upc_q),
        .map_addr  (bus.map_addr),
        .mi_next   (bus.mi_next),
        .z_flag    (bus.z_flag),
        .mem_ready (bus.mem_ready),
        .next_upc  (cand_upc)
    );

    assign unmapped = (bus.map_addr == UPC_UNMAPPED);

    always_comb begin
        state_nx = state;
        upc_nx   = upc_q;
        cnt_nx   = cnt_q;
        done_nx  = 1'b0;
        case (state)
            ST_IDLE, ST_HALT: begin
                if (bus.start) begin
                    state_nx = ST_RUN;
                    upc_nx   = UPC_FETCH;
                    cnt_nx   = '0;
                end
            end
            ST_RUN: begin
                upc_nx = cand_upc;
                case (seq_t'(bus.mi_seq))
                    SEQ_MAP: begin
                        if (unmapped) begin
                            state_nx = ST_ERR;
                            upc_nx   = UPC_UNMAPPED;
                        end else if (cnt_q != '1) begin
                            cnt_nx = cnt_q + CNT_W'(1);
                        end
                    end
                    SEQ_WAIT: if (!bus.mem_ready) state_nx = ST_WAITM;
                    SEQ_HALT: begin
                        state_nx = ST_HALT;
                        done_nx  = 1'b1;
                    end
                    default: ;
                endcase
            end
            // The stalled WAIT microinstruction completes here; the field is not re-decoded.
            ST_WAITM: begin
                if (bus.mem_ready) begin
                    state_nx = ST_RUN;
                    upc_nx   = upc_q + UADDR_W'(1);
                end
            end
            ST_ERR:   upc_nx = UPC_UNMAPPED;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            upc_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            upc_q  <= upc_nx;
            cnt_q  <= cnt_nx;
            done_q <= done_nx;
        end
    end

    assign bus.upc       = upc_q;
    assign bus.busy      = (state == ST_RUN) || (state == ST_WAITM);
    assign bus.stall     = (state == ST_WAITM);
    assign bus.done      = done_q;
    assign bus.illegal   = (state == ST_ERR);
    assign bus.instr_cnt = cnt_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: stimulus updates a behavioural model and queues
// the expected post-edge outputs; a negedge monitor pops and compares them.
module tb_micro_sequencer;

    localparam int UADDR_W = 5;
    localparam int CNT_W   = 16;
    localparam int NADDR   = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    micro_sequencer_if #(.UADDR_W(UADDR_W), .CNT_W(CNT_W)) bus ();

    micro_sequencer #(.UADDR_W(UADDR_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int tag;
        int upc;
        bit busy;
        bit stall;
        bit done;
        bit illegal;
        int cnt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cycle_no = 0;

    // Reference model: phase names and plain integer arithmetic.
    string m_phase = "idle";
    int    m_upc   = 0;
    int    m_cnt   = 0;
    bit    m_done  = 1'b0;

    always @(posedge clk) cycle_no <= cycle_no + 1;

    task automatic check(input bit ok, input string what);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s", what);
        end
    endtask

    task automatic model_step(input bit r, input bit s, input int seq, input int nxt,
                              input bit z, input bit mr, input int map);
        m_done = 1'b0;
        if (r) begin
            m_phase = "idle";
            m_upc   = 0;
            m_cnt   = 0;
        end else if (m_phase == "idle" || m_phase == "halt") begin
            if (s) begin
                m_phase = "run";
                m_upc   = 0;
                m_cnt   = 0;
            end
        end else if (m_phase == "run") begin
            case (seq)
                0: m_upc = (m_upc + 1) % NADDR;
                1: begin
                    if (map == 31) begin
                        m_upc   = 31;
                        m_phase = "err";
                    end else begin
                        m_upc = map;
                        if (m_cnt < 65535) m_cnt = m_cnt + 1;
                    end
                end
                2: m_upc = nxt;
                3: m_upc = z ? nxt : (m_upc + 1) % NADDR;
                4: m_upc = z ? (m_upc + 1) % NADDR : nxt;
                5: m_upc = 0;
                6: begin
                    if (mr) m_upc = (m_upc + 1) % NADDR;
                    else    m_phase = "wait";
                end
                default: begin
                    m_phase = "halt";
                    m_done  = 1'b1;
                end
            endcase
        end else if (m_phase == "wait") begin
            if (mr) begin
                m_upc   = (m_upc + 1) % NADDR;
                m_phase = "run";
            end
        end
    endtask

    task automatic cyc(input bit r, input bit s, input int seq, input int nxt,
                       input bit z, input bit mr, input int map);
        exp_t e;
        @(posedge clk);
        #1;
        rst           = r;
        bus.start     = s;
        bus.mi_seq    = seq[2:0];
        bus.mi_next   = nxt[UADDR_W-1:0];
        bus.z_flag    = z;
        bus.mem_ready = mr;
        bus.map_addr  = map[UADDR_W-1:0];
        model_step(r, s, seq, nxt, z, mr, map);
        e.tag     = cycle_no + 1;
        e.upc     = m_upc;
        e.busy    = (m_phase == "run") || (m_phase == "wait");
        e.stall   = (m_phase == "wait");
        e.done    = m_done;
        e.illegal = (m_phase == "err");
        e.cnt     = m_cnt;
        sb.push_back(e);
    endtask

    task automatic run(input int seq, input int nxt, input bit z, input bit mr, input int map);
        cyc(1'b0, 1'b0, seq, nxt, z, mr, map);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].tag <= cycle_no) begin
            e = sb.pop_front();
            check(e.tag == cycle_no &&
                  bus.upc === UADDR_W'(e.upc) && bus.busy === e.busy && bus.stall === e.stall &&
                  bus.done === e.done && bus.illegal === e.illegal && bus.instr_cnt === CNT_W'(e.cnt),
                  $sformatf("cycle%0d: got upc=%0d busy=%b stall=%b done=%b illegal=%b cnt=%0d, want upc=%0d busy=%b stall=%b done=%b illegal=%b cnt=%0d (tag %0d)",
                            cycle_no, bus.upc, bus.busy, bus.stall, bus.done, bus.illegal, bus.instr_cnt,
                            e.upc, e.busy, e.stall, e.done, e.illegal, e.cnt, e.tag));
        end
    end

    initial begin
        bit r, s;
        bus.start = 1'b0; bus.mi_seq = '0; bus.mi_next = '0;
        bus.z_flag = 1'b0; bus.mem_ready = 1'b0; bus.map_addr = '0;

        // Reset, start, two increments
        cyc(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check(bus.upc === '0 && bus.busy === 1'b0 && bus.stall === 1'b0 &&
              bus.done === 1'b0 && bus.illegal === 1'b0 && bus.instr_cnt === '0,
              $sformatf("reset state: upc=%0d busy=%b stall=%b done=%b illegal=%b cnt=%0d",
                        bus.upc, bus.busy, bus.stall, bus.done, bus.illegal, bus.instr_cnt));
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        run(0, 0, 0, 0, 0);
        run(0, 0, 0, 0, 0);
        // Dispatch from upc=4, then an unmapped opcode
        run(2, 4, 0, 0, 0);
        run(1, 0, 0, 0, 17);
        run(1, 0, 0, 0, 31);
        cyc(0, 1, 0, 0, 0, 1, 3);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        // Conditional branches from upc=10 toward 9
        run(2, 10, 0, 0, 0); run(3, 9, 1, 0, 0);
        run(2, 10, 0, 0, 0); run(3, 9, 0, 0, 0);
        run(2, 10, 0, 0, 0); run(4, 9, 1, 0, 0);
        run(2, 10, 0, 0, 0); run(4, 9, 0, 0, 0);
        // Memory wait at upc=20 for three cycles
        run(2, 20, 0, 0, 0);
        run(6, 0, 0, 0, 0);
        run(6, 0, 0, 0, 0);
        run(6, 0, 0, 0, 0);
        @(negedge clk);
        check(bus.stall === 1'b1 && bus.busy === 1'b1 && bus.upc === UADDR_W'(20),
              $sformatf("memory wait: stall=%b busy=%b upc=%0d", bus.stall, bus.busy, bus.upc));
        run(6, 0, 0, 1, 0);
        run(6, 0, 0, 1, 0);
        // Halt at upc=26, idle a cycle, restart
        run(2, 26, 0, 0, 0);
        run(7, 0, 0, 0, 0);
        run(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        // Wrap from 31, fetch, then reset while stalled
        run(2, 31, 0, 0, 0);
        run(0, 0, 0, 0, 0);
        run(2, 7, 0, 0, 0);
        run(5, 0, 0, 0, 0);
        run(2, 5, 0, 0, 0);
        run(6, 0, 0, 0, 0);
        cyc(1, 1, 6, 3, 1, 1, 9);
        run(0, 0, 0, 0, 0);

        // Random traffic; reset is frequent once the model is in the error state
        for (int i = 0; i < 800; i++) begin
            if (m_phase == "err") r = ($urandom_range(0, 3) == 0);
            else                  r = ($urandom_range(0, 199) == 0);
            s = ($urandom_range(0, 7) == 0);
            cyc(r, s, $urandom_range(0, 7), $urandom_range(0, 31), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 19) == 0) ? 31 : $urandom_range(0, 30));
        end

        run(0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
